mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one OBI-style memory port between NUM_PORTS core-side requesters, e.g. instr + data,
//   ahead of the single AXI bridge. Round-robin arbitration; requests pass through combinationally.
//   Tracks outstanding transactions in order and routes each response back to its issuing port.
//   The downstream bridge is strictly in-order, so a FIFO of port indices is sufficient.
// PARAMETERS
//   NUM_PORTS        2   number of requesters (>=2)
//   ADDR_WIDTH       32  address width
//   DATA_WIDTH       32  data width; byte enables are DATA_WIDTH/8
//   MAX_OUTSTANDING  1   max granted-but-unanswered transactions (>=1); ID FIFO depth
// PORTS
//   clk_i         in   1                       clock
//   rst_ni        in   1                       async reset, active low
//   req_i         in   NUM_PORTS               per-port request
//   gnt_o         out  NUM_PORTS               per-port grant
//   rvalid_o      out  NUM_PORTS               per-port response valid
//   addr_i        in   NUM_PORTS*ADDR_WIDTH    per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   we_i          in   NUM_PORTS               per-port write enable
//   be_i          in   NUM_PORTS*DATA_WIDTH/8  per-port byte enables
//   wdata_i       in   NUM_PORTS*DATA_WIDTH    per-port write data
//   rdata_o       out  DATA_WIDTH              response data, broadcast to all ports
//   m_req_o       out  1                       downstream request
//   m_gnt_i       in   1                       downstream grant
//   m_addr_o      out  ADDR_WIDTH              downstream address
//   m_we_o        out  1                       downstream write enable
//   m_be_o        out  DATA_WIDTH/8            downstream byte enables
//   m_wdata_o     out  DATA_WIDTH              downstream write data
//   m_rvalid_i    in   1                       downstream response valid
//   m_rdata_i     in   DATA_WIDTH              downstream response data
//   rsp_err_o     out  1                       1-cycle pulse: m_rvalid_i arrived with no outstanding entry
// BEHAVIOUR
//   Reset: gnt_o=0, rvalid_o=0, m_req_o=0, rsp_err_o=0; rr_ptr=0, count=0, lock=0, FIFO empty.
//   full = (count == MAX_OUTSTANDING).
//   Selection: if lock=1, sel=lock_idx. Otherwise sel = first p with req_i[p]=1, searching
//     from rr_ptr upward and wrapping modulo NUM_PORTS.
//   m_req_o = any(req_i) & !full; m_addr/we/be/wdata_o = port sel fields (0 when m_req_o=0).
//   Downstream handshake hs = m_req_o & m_gnt_i; gnt_o[sel] = hs; all other grants are 0.
//     Zero-cycle req->m_req and m_gnt->gnt paths; there is no rvalid->req combinational path.
//   Lock (OBI stability): on m_req_o & !m_gnt_i, set lock=1 and lock_idx=sel.
//     Cleared on hs. A higher-priority request arriving while locked must not switch the port.
//   Round robin: on hs, rr_ptr = (sel+1) mod NUM_PORTS. No hs -> pointer unchanged.
//   Requester rule: req_i and its fields must stay stable from assertion until gnt.
//     Violations are undefined; the bench asserts the rule.
//   ID FIFO: on hs, push sel. On m_rvalid_i with count>0, pop head.
//     The popped entry drives rvalid_o[head]=1 in the same cycle.
//   rdata_o = m_rdata_i. Response latency is 0 cycles from m_rvalid_i.
//   Count: push only -> +1; pop only -> -1; push and pop together -> unchanged (count>0 required).
//   Full blocks new requests even if a pop happens in the same cycle.
//   Empty + m_rvalid_i: rvalid_o stays 0, rsp_err_o=1 for one cycle, state unchanged.
//   Writes receive a response like reads (OBI), so writes are also tracked in the FIFO.
//   Reset mid-transaction: all outstanding entries are discarded.
//     The downstream bridge shares rst_ni and resets too.
// TESTING
//   1. P0 reads alone at 0x100, m_gnt_i=1, rvalid 2 cycles later with rdata=0xCAFE0001
//      -> gnt_o=01, then rvalid_o=01 with rdata_o=0xCAFE0001; count returns to 0.
//   2. P0 and P1 request every cycle, MAX_OUTSTANDING=4, immediate gnt
//      -> grants alternate 01,10,01,10; responses route in issue order.
//   3. P1 requests, m_gnt_i held 0 for 3 cycles, P0 raises req in cycle 2
//      -> m_addr_o stays P1's address, and the first grant goes to P1.
//   4. MAX_OUTSTANDING=1, P0 granted, rvalid delayed 5 cycles
//      -> m_req_o=0 for those cycles; P1 is granted only in the cycle after rvalid.
//   5. m_rvalid_i pulse with no outstanding transaction
//      -> rsp_err_o=1 for 1 cycle, rvalid_o=0, count stays 0.
//   6. rst_ni asserted with 2 outstanding -> all outputs 0, FIFO empty, rr_ptr=0 at next request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one OBI-style memory port between
// NUM_PORTS requesters. Requests pass through combinationally; an in-order FIFO
// of port indices routes each downstream response back to its issuing port.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              m_req_o,
    input  logic                              m_gnt_i,
    output logic [ADDR_WIDTH-1:0]             m_addr_o,
    output logic                              m_we_o,
    output logic [DATA_WIDTH/8-1:0]           m_be_o,
    output logic [DATA_WIDTH-1:0]             m_wdata_o,
    input  logic                              m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             m_rdata_i,
    output logic                              rsp_err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = $clog2(NUM_PORTS);
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                             lock_q, lock_d;
    logic [IDX_W-1:0]                 lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [PTR_W-1:0]                 wptr_q, wptr_d;
    logic [PTR_W-1:0]                 rptr_q, rptr_d;
    logic [MAX_OUTSTANDING*IDX_W-1:0] fifo_q, fifo_d;

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] head;
    logic             found;
    logic             full;
    logic             hs;
    logic             pop;

    // Pick the port to forward: the locked port while a request is stalled,
    // otherwise the first requester at or after the round-robin pointer.
    always_comb begin
        sel   = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_PORTS);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    // Downstream request path, grant fan-out and response routing.
    always_comb begin
        full      = (count_q == CNT_FULL);
        m_req_o   = (|req_i) & ~full;
        hs        = m_req_o & m_gnt_i;
        head      = fifo_q[32'(rptr_q)*IDX_W +: IDX_W];
        pop       = m_rvalid_i & (count_q != '0);
        rsp_err_o = m_rvalid_i & (count_q == '0);
        rdata_o   = m_rdata_i;
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        gnt_o     = '0;
        rvalid_o  = '0;
        if (m_req_o) begin
            m_addr_o  = addr_i[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            m_we_o    = we_i[sel];
            m_be_o    = be_i[32'(sel)*BE_WIDTH +: BE_WIDTH];
            m_wdata_o = wdata_i[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (hs) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            rvalid_o[head] = 1'b1;
        end
    end

    // Next-state: pointer advance, stall lock, ID FIFO push/pop and occupancy.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_d     = fifo_q;
        if (hs) begin
            rr_ptr_d = (sel == IDX_LAST) ? '0 : sel + 1'b1;
            lock_d   = 1'b0;
            fifo_d[32'(wptr_q)*IDX_W +: IDX_W] = sel;
            wptr_d   = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end else if (m_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        case ({hs, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any outstanding entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with a single outstanding
// slot (u1) and one with four (u4), driven by shared stimulus.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    logic [1:0]  g1, rv1, g4, rv4;
    logic [31:0] rd1, rd4, maddr1, maddr4, mwd1, mwd4;
    logic        mreq1, mreq4, mwe1, mwe4, err1, err4;
    logic [3:0]  mbe1, mbe4;

    int tests = 0;
    int fails = 0;
    bit tgt1 = 1'b0;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(g1), .rvalid_o(rv1),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rd1),
        .m_req_o(mreq1), .m_gnt_i(m_gnt), .m_addr_o(maddr1), .m_we_o(mwe1), .m_be_o(mbe1),
        .m_wdata_o(mwd1), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .rsp_err_o(err1));

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(g4), .rvalid_o(rv4),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rd4),
        .m_req_o(mreq4), .m_gnt_i(m_gnt), .m_addr_o(maddr4), .m_we_o(mwe4), .m_be_o(mbe4),
        .m_wdata_o(mwd4), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .rsp_err_o(err4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester rule: a request not yet granted by the instance under test stays up with stable address.
    logic [1:0]  p_req, p_gnt;
    logic [63:0] p_addr;
    logic        p_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && p_rst) begin
            for (int p = 0; p < 2; p++) begin
                if (p_req[p] && !p_gnt[p]) begin
                    assert (req[p] && addr[p*32 +: 32] == p_addr[p*32 +: 32])
                        else $error("requester rule broken on port %0d", p);
                end
            end
        end
        p_req  <= req;
        p_gnt  <= tgt1 ? g1 : g4;
        p_addr <= addr;
        p_rst  <= rst_n;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; addr = '0; we = '0; be = '0; wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        #1;
        tests++; if (g4 !== 2'b00) begin fails++; $display("FAIL reset_gnt4 got %b exp 00", g4); end
        tests++; if (rv4 !== 2'b00) begin fails++; $display("FAIL reset_rvalid4 got %b exp 00", rv4); end
        tests++; if (mreq4 !== 1'b0) begin fails++; $display("FAIL reset_mreq4 got %b exp 0", mreq4); end
        tests++; if (err4 !== 1'b0) begin fails++; $display("FAIL reset_err4 got %b exp 0", err4); end
        tests++; if (mreq1 !== 1'b0 || g1 !== 2'b00) begin fails++; $display("FAIL reset_u1 got mreq=%b gnt=%b exp 0/00", mreq1, g1); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        tgt1 = 1'b1;
        do_reset();
        cyc(); req = 2'b01; addr[31:0] = 32'h100; m_gnt = 1'b1; #1;
        tests++; if (mreq1 !== 1'b1) begin fails++; $display("FAIL rd_mreq got %b exp 1", mreq1); end
        tests++; if (maddr1 !== 32'h100) begin fails++; $display("FAIL rd_maddr got %h exp 00000100", maddr1); end
        tests++; if (g1 !== 2'b01) begin fails++; $display("FAIL rd_gnt got %b exp 01", g1); end
        cyc(); req = 2'b00; m_gnt = 1'b0; #1;
        tests++; if (mreq1 !== 1'b0 || g1 !== 2'b00 || maddr1 !== 32'h0) begin fails++; $display("FAIL rd_idle got mreq=%b gnt=%b addr=%h exp 0/00/0", mreq1, g1, maddr1); end
        cyc(); m_rvalid = 1'b1; m_rdata = 32'hCAFE0001; #1;
        tests++; if (rv1 !== 2'b01) begin fails++; $display("FAIL rd_rvalid got %b exp 01", rv1); end
        tests++; if (rd1 !== 32'hCAFE0001) begin fails++; $display("FAIL rd_rdata got %h exp cafe0001", rd1); end
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL rd_err got %b exp 0", err1); end
        cyc(); m_rvalid = 1'b0; req = 2'b10; addr[63:32] = 32'h180; m_gnt = 1'b1; #1;
        tests++; if (g1 !== 2'b10 || maddr1 !== 32'h180) begin fails++; $display("FAIL rd_count0 got gnt=%b addr=%h exp 10/00000180", g1, maddr1); end
        cyc(); idle_inputs();
    endtask

    task automatic test_round_robin();
        tgt1 = 1'b0;
        do_reset();
        cyc(); req = 2'b11; addr = {32'h300, 32'h200}; m_gnt = 1'b1; #1;
        tests++; if (g4 !== 2'b01 || maddr4 !== 32'h200) begin fails++; $display("FAIL rr_c1 got gnt=%b addr=%h exp 01/00000200", g4, maddr4); end
        cyc(); #1;
        tests++; if (g4 !== 2'b10 || maddr4 !== 32'h300) begin fails++; $display("FAIL rr_c2 got gnt=%b addr=%h exp 10/00000300", g4, maddr4); end
        cyc(); #1;
        tests++; if (g4 !== 2'b01) begin fails++; $display("FAIL rr_c3 got gnt=%b exp 01", g4); end
        cyc(); #1;
        tests++; if (g4 !== 2'b10) begin fails++; $display("FAIL rr_c4 got gnt=%b exp 10", g4); end
        // four outstanding: full blocks P0 even while a response pops
        cyc(); req = 2'b01; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hD0; #1;
        tests++; if (mreq4 !== 1'b0 || g4 !== 2'b00) begin fails++; $display("FAIL rr_full got mreq=%b gnt=%b exp 0/00", mreq4, g4); end
        tests++; if (rv4 !== 2'b01 || rd4 !== 32'hD0) begin fails++; $display("FAIL rr_rsp1 got rvalid=%b data=%h exp 01/000000d0", rv4, rd4); end
        cyc(); m_rdata = 32'hD1; #1;
        tests++; if (g4 !== 2'b01 || rv4 !== 2'b10) begin fails++; $display("FAIL rr_pushpop got gnt=%b rvalid=%b exp 01/10", g4, rv4); end
        cyc(); req = 2'b00; m_gnt = 1'b0; m_rdata = 32'hD2; #1;
        tests++; if (rv4 !== 2'b01 || mreq4 !== 1'b0) begin fails++; $display("FAIL rr_rsp3 got rvalid=%b mreq=%b exp 01/0", rv4, mreq4); end
        cyc(); m_rdata = 32'hD3; #1;
        tests++; if (rv4 !== 2'b10) begin fails++; $display("FAIL rr_rsp4 got rvalid=%b exp 10", rv4); end
        cyc(); m_rdata = 32'hD4; #1;
        tests++; if (rv4 !== 2'b01 || err4 !== 1'b0) begin fails++; $display("FAIL rr_rsp5 got rvalid=%b err=%b exp 01/0", rv4, err4); end
        cyc(); #1;
        tests++; if (err4 !== 1'b1 || rv4 !== 2'b00) begin fails++; $display("FAIL rr_empty got err=%b rvalid=%b exp 1/00", err4, rv4); end
        cyc(); idle_inputs();
    endtask

    task automatic test_lock();
        tgt1 = 1'b0;
        do_reset();
        cyc(); req = 2'b10; addr[63:32] = 32'h444; we = 2'b10; be = 8'hA0; wdata[63:32] = 32'h1234_5678; #1;
        tests++; if (mreq4 !== 1'b1 || maddr4 !== 32'h444 || g4 !== 2'b00) begin fails++; $display("FAIL lk_c1 got mreq=%b addr=%h gnt=%b exp 1/00000444/00", mreq4, maddr4, g4); end
        tests++; if (mwe4 !== 1'b1 || mbe4 !== 4'hA || mwd4 !== 32'h1234_5678) begin fails++; $display("FAIL lk_fields got we=%b be=%h wd=%h exp 1/a/12345678", mwe4, mbe4, mwd4); end
        cyc(); req = 2'b11; addr[31:0] = 32'h111; #1;
        tests++; if (maddr4 !== 32'h444 || g4 !== 2'b00) begin fails++; $display("FAIL lk_c2 got addr=%h gnt=%b exp 00000444/00", maddr4, g4); end
        cyc(); #1;
        tests++; if (maddr4 !== 32'h444) begin fails++; $display("FAIL lk_c3 got addr=%h exp 00000444", maddr4); end
        cyc(); m_gnt = 1'b1; #1;
        tests++; if (g4 !== 2'b10 || maddr4 !== 32'h444) begin fails++; $display("FAIL lk_gnt got gnt=%b addr=%h exp 10/00000444", g4, maddr4); end
        cyc(); req = 2'b01; we = 2'b00; #1;
        tests++; if (g4 !== 2'b01 || maddr4 !== 32'h111 || mwe4 !== 1'b0) begin fails++; $display("FAIL lk_next got gnt=%b addr=%h we=%b exp 01/00000111/0", g4, maddr4, mwe4); end
        cyc(); idle_inputs();
    endtask

    task automatic test_full_block();
        tgt1 = 1'b1;
        do_reset();
        cyc(); req = 2'b01; addr = {32'h600, 32'h500}; m_gnt = 1'b1; #1;
        tests++; if (g1 !== 2'b01) begin fails++; $display("FAIL fb_first got gnt=%b exp 01", g1); end
        cyc(); req = 2'b10; #1;
        for (int k = 0; k < 5; k++) begin
            tests++; if (mreq1 !== 1'b0 || g1 !== 2'b00) begin fails++; $display("FAIL fb_wait%0d got mreq=%b gnt=%b exp 0/00", k, mreq1, g1); end
            cyc(); #1;
        end
        m_rvalid = 1'b1; m_rdata = 32'hBEEF; #1;
        tests++; if (rv1 !== 2'b01 || mreq1 !== 1'b0 || g1 !== 2'b00) begin fails++; $display("FAIL fb_pop got rvalid=%b mreq=%b gnt=%b exp 01/0/00", rv1, mreq1, g1); end
        cyc(); m_rvalid = 1'b0; #1;
        tests++; if (g1 !== 2'b10 || maddr1 !== 32'h600) begin fails++; $display("FAIL fb_p1 got gnt=%b addr=%h exp 10/00000600", g1, maddr1); end
        cyc(); req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
        tests++; if (rv1 !== 2'b10) begin fails++; $display("FAIL fb_rsp_p1 got rvalid=%b exp 10", rv1); end
        cyc(); idle_inputs();
    endtask

    task automatic test_orphan_rsp();
        tgt1 = 1'b1;
        do_reset();
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h5555; #1;
        tests++; if (err4 !== 1'b1 || rv4 !== 2'b00 || err1 !== 1'b1) begin fails++; $display("FAIL or_err got err4=%b rv4=%b err1=%b exp 1/00/1", err4, rv4, err1); end
        cyc(); m_rvalid = 1'b0; #1;
        tests++; if (err4 !== 1'b0) begin fails++; $display("FAIL or_pulse got err=%b exp 0", err4); end
        cyc(); req = 2'b01; m_gnt = 1'b1; #1;
        tests++; if (g1 !== 2'b01) begin fails++; $display("FAIL or_cnt0 got gnt=%b exp 01", g1); end
        cyc(); req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
        tests++; if (rv1 !== 2'b01 || err1 !== 1'b0) begin fails++; $display("FAIL or_rsp got rvalid=%b err=%b exp 01/0", rv1, err1); end
        cyc(); #1;
        tests++; if (err1 !== 1'b1 || rv1 !== 2'b00) begin fails++; $display("FAIL or_drain got err=%b rvalid=%b exp 1/00", err1, rv1); end
        cyc(); idle_inputs();
    endtask

    task automatic test_reset_mid();
        tgt1 = 1'b0;
        do_reset();
        cyc(); req = 2'b01; addr = {32'h900, 32'h800}; m_gnt = 1'b1; #1;
        tests++; if (g4 !== 2'b01) begin fails++; $display("FAIL rm_g1 got gnt=%b exp 01", g4); end
        cyc(); #1;
        tests++; if (g4 !== 2'b01) begin fails++; $display("FAIL rm_g2 got gnt=%b exp 01", g4); end
        cyc(); idle_inputs(); rst_n = 1'b0; #1;
        tests++; if (g4 !== 2'b00 || rv4 !== 2'b00 || mreq4 !== 1'b0 || err4 !== 1'b0) begin fails++; $display("FAIL rm_outs got gnt=%b rv=%b mreq=%b err=%b exp 00/00/0/0", g4, rv4, mreq4, err4); end
        cyc(); rst_n = 1'b1;
        cyc(); req = 2'b11; addr = {32'h900, 32'h800}; m_gnt = 1'b1; #1;
        tests++; if (g4 !== 2'b01 || maddr4 !== 32'h800) begin fails++; $display("FAIL rm_ptr got gnt=%b addr=%h exp 01/00000800", g4, maddr4); end
        cyc(); req = 2'b10; #1;
        tests++; if (g4 !== 2'b10) begin fails++; $display("FAIL rm_p1 got gnt=%b exp 10", g4); end
        cyc(); req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
        tests++; if (rv4 !== 2'b01) begin fails++; $display("FAIL rm_rsp1 got rvalid=%b exp 01", rv4); end
        cyc(); #1;
        tests++; if (rv4 !== 2'b10) begin fails++; $display("FAIL rm_rsp2 got rvalid=%b exp 10", rv4); end
        cyc(); #1;
        tests++; if (err4 !== 1'b1 || rv4 !== 2'b00) begin fails++; $display("FAIL rm_empty got err=%b rvalid=%b exp 1/00", err4, rv4); end
        cyc(); idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_full_block();
        test_orphan_rsp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
